ldpc_parity_accum_nut: RTL and testbench
========================================

// Module: ldpc_parity_accum_nut
// PURPOSE
// - Parametrised successor of the 1-unit byte-select/XOR-accumulate LDPC stage of the DVB-S2 encoder.
// - Selects an OUT_W slice of a DATA_W-bit parity-address RAM word and rotates it.
// - XOR-accumulates the slice into an addressable parity bank.
// - At frame end, drains the bank as OUT_W words over a valid/ready stream.
// - Optional mode: running-XOR (accumulator) post-processing across the serial bit stream.
// PARAMETERS
// - DATA_W     360  width of ram_data word
// - OUT_W      8    slice / parity word width; DATA_W % OUT_W == 0
// - NUM_SLICE  45   DATA_W/OUT_W; slice_sel legal range 0..NUM_SLICE-1
// - PAR_WORDS  45   parity bank depth in OUT_W words
// - ADDR_W     6    width of par_addr and slice_sel; 2**ADDR_W >= max(PAR_WORDS, NUM_SLICE)
// - ROT_W      3    width of bit_rot = clog2(OUT_W)
// PORTS
// - sys_clk    in   1        single clock
// - rst        in   1        synchronous, active-high reset
// - fs_en      in   1        clock enable; state, pipeline and handshakes advance only when 1
// - mode       in   1        0 = plain XOR bank; 1 = running-XOR chain on drain; sampled at frame_start
// - frame_start in  1        clears bank and chain; IDLE -> ACCUM
// - in_vld     in   1        accumulate beat valid (ACCUM only)
// - ram_data   in   DATA_W   parity-address RAM word
// - slice_sel  in   ADDR_W   slice index; slice = ram_data[slice_sel*OUT_W +: OUT_W]
// - bit_rot    in   ROT_W    left-rotate amount applied to slice
// - par_addr   in   ADDR_W   bank word to XOR into
// - frame_end  in   1        last beat already given; ACCUM -> DRAIN
// - in_ready   out  1        1 in ACCUM only
// - out_valid  out  1        drain word valid
// - out_ready  in   1        downstream accept
// - byte_out   out  OUT_W    parity word, MSB = first serial bit
// - out_last   out  1        with final drain word (index PAR_WORDS-1)
// - err        out  1        sticky: illegal slice_sel/par_addr, or in_vld outside ACCUM
// BEHAVIOUR
// - Reset (rst=1 at edge, regardless of fs_en): FSM=IDLE, bank=0, chain=0, pipeline empty.
//   in_ready=0, out_valid=0, byte_out=0, out_last=0, err=0.
//   Reset mid-frame aborts the frame; no partial output.
// - FSM states: IDLE, ACCUM, FLUSH, DRAIN.
//   - IDLE  --frame_start-->    ACCUM
//   - ACCUM --frame_end-->      FLUSH
//   - FLUSH --pipe empty-->     DRAIN (2 enabled cycles)
//   - DRAIN --last word accepted--> IDLE
//   - frame_start outside IDLE: ignored.
//   - frame_start & frame_end in same cycle in IDLE: frame_end ignored.
// - Accumulate pipeline, 2 enabled cycles:
//   - S1 registers rotated slice + addr.
//   - S2 writes bank[addr] ^= slice.
//   - Back-to-back beats to the same addr forward the S2 result; no lost XOR.
//   - Beat with in_vld and frame_end together: beat accepted, then FLUSH.
// - Illegal beats: slice_sel >= NUM_SLICE or par_addr >= PAR_WORDS -> beat dropped, err=1.
//   in_vld outside ACCUM -> err=1. err clears only on rst.
// - Drain: word i = 0..PAR_WORDS-1 in order.
//   - mode 0: byte_out = bank[i].
//   - mode 1: serial bits MSB-first; out bit = bank bit XOR all previous bits.
//     Chain carries across words, reset per frame.
//   - out_valid asserts 1 cycle after DRAIN entry.
//   - byte_out/out_last held stable while out_valid & !out_ready.
//   - One word per enabled cycle under out_ready=1.
//   - fs_en=0 freezes everything; a transfer needs out_valid & out_ready & fs_en.
// - Rotation: rot = {s, s} >> (OUT_W - bit_rot), low OUT_W bits; bit_rot=0 passes through.
// STRUCTURE
// - Shared package ldpc_pkg: FSM state encoding, default DATA_W/OUT_W/NUM_SLICE, mode constants.
// - One sub-module ldpc_slice_rot: combinational slice select + rotate; legal flag.
// - Bank as register array PAR_WORDS x OUT_W.
// TESTING
// - Single beat (ram_data slice 3 = 8'hA5, slice_sel=3, bit_rot=0, par_addr=0), mode 0
//   -> word0=8'hA5, other 44 words 0, out_last on word 44.
// - Same beat twice back-to-back to addr 7 -> word7=8'h00 (forwarding).
//   8'h81 then 8'h01 -> 8'h80.
// - bit_rot=1 on 8'h81 -> 8'h03.
// - mode 1, word0=8'h80, rest 0 -> drain word0=8'hFF, all later words 8'hFF (chain carry).
// - out_ready toggling 1010..., plus fs_en=0 bursts
//   -> all 45 words in order, no duplicates, data stable while stalled.
// - slice_sel=45 or par_addr=45 -> err=1, bank unchanged.
//   rst mid-DRAIN -> out_valid=0 next cycle, state IDLE.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared constants for the LDPC parity accumulate stage:
// FSM encoding, default geometry and drain mode values.
package ldpc_pkg;

  localparam int DATA_W_D    = 360;
  localparam int OUT_W_D     = 8;
  localparam int NUM_SLICE_D = 45;
  localparam int PAR_WORDS_D = 45;
  localparam int ADDR_W_D    = 6;
  localparam int ROT_W_D     = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic MODE_XOR   = 1'b0;
  localparam logic MODE_CHAIN = 1'b1;

endpackage

// File: rtl/ldpc_parity_accum_nut_slice_rot.sv
// Combinational slice select and left-rotate of a RAM word,
// with a flag for an in-range slice index.
module ldpc_slice_rot
  import ldpc_pkg::*;
#(
  parameter int DATA_W    = DATA_W_D,
  parameter int OUT_W     = OUT_W_D,
  parameter int NUM_SLICE = NUM_SLICE_D,
  parameter int ADDR_W    = ADDR_W_D,
  parameter int ROT_W     = ROT_W_D
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_sel,
  input  logic [ROT_W-1:0]  i_rot,
  output logic [OUT_W-1:0]  o_slice,
  output logic              o_legal
);

  localparam logic [ADDR_W-1:0] SEL_LIM =
    ADDR_W'(NUM_SLICE);

  logic [ADDR_W-1:0]  w_idx;
  logic [OUT_W-1:0]   w_raw;
  logic [2*OUT_W-1:0] w_dbl;

  assign o_legal = i_sel < SEL_LIM;
  // Illegal indices read slice 0; the beat is dropped anyway.
  assign w_idx   = o_legal ? i_sel : '0;
  assign w_raw   = i_data[int'(w_idx)*OUT_W +: OUT_W];
  assign w_dbl   = {w_raw, w_raw} >> (OUT_W - int'(i_rot));
  assign o_slice = w_dbl[OUT_W-1:0];

endmodule

// File: rtl/ldpc_parity_accum_nut.sv
// LDPC parity stage: XOR-accumulate rotated RAM slices into a
// parity bank, then drain it as a valid/ready word stream.
module ldpc_parity_accum_nut
  import ldpc_pkg::*;
#(
  parameter int DATA_W    = DATA_W_D,
  parameter int OUT_W     = OUT_W_D,
  parameter int NUM_SLICE = NUM_SLICE_D,
  parameter int PAR_WORDS = PAR_WORDS_D,
  parameter int ADDR_W    = ADDR_W_D,
  parameter int ROT_W     = ROT_W_D
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              fs_en,
  input  logic              mode,
  input  logic              frame_start,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] ram_data,
  input  logic [ADDR_W-1:0] slice_sel,
  input  logic [ROT_W-1:0]  bit_rot,
  input  logic [ADDR_W-1:0] par_addr,
  input  logic              frame_end,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  byte_out,
  output logic              out_last,
  output logic              err
);

  localparam logic [ADDR_W-1:0] PW_LIM  =
    ADDR_W'(PAR_WORDS);
  localparam logic [ADDR_W-1:0] PW_LAST =
    ADDR_W'(PAR_WORDS - 1);

  logic [1:0]        r_state;
  logic              r_mode;
  logic [OUT_W-1:0]  r_bank [PAR_WORDS];
  logic              r_s1_vld;
  logic [OUT_W-1:0]  r_s1_data;
  logic [ADDR_W-1:0] r_s1_addr;
  logic              r_flush;
  logic [ADDR_W-1:0] r_idx;
  logic              r_chain;
  logic              r_out_valid;
  logic              r_last;
  logic              r_err;
  logic [OUT_W-1:0]  r_byte;

  logic [OUT_W-1:0]  w_rot;
  logic              w_sel_ok;
  logic              w_addr_ok;
  logic              w_beat;
  logic              w_more;
  logic              w_load;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [OUT_W-1:0]  w_word;
  logic [OUT_W-1:0]  w_cw;
  logic              w_c;

  ldpc_slice_rot #(
    .DATA_W    (DATA_W),
    .OUT_W     (OUT_W),
    .NUM_SLICE (NUM_SLICE),
    .ADDR_W    (ADDR_W),
    .ROT_W     (ROT_W)
  ) u_rot (
    .i_data  (ram_data),
    .i_sel   (slice_sel),
    .i_rot   (bit_rot),
    .o_slice (w_rot),
    .o_legal (w_sel_ok)
  );

  assign w_addr_ok = par_addr < PW_LIM;
  assign w_beat    = in_vld & (r_state == S_ACCUM);
  assign w_more    = r_idx < PW_LIM;
  assign w_xfer    = fs_en & r_out_valid & out_ready;
  assign w_load    = fs_en & (r_state == S_DRAIN) & w_more
                   & (~r_out_valid | out_ready);
  assign w_rd_idx  = w_more ? r_idx : '0;
  assign w_word    = r_bank[w_rd_idx];

  // Serial MSB-first running XOR, seeded by the previous word.
  always_comb begin
    w_c  = r_chain;
    w_cw = '0;
    for (int j = OUT_W - 1; j >= 0; j--) begin
      w_c     = w_c ^ w_word[j];
      w_cw[j] = w_c;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= MODE_XOR;
      r_s1_vld    <= 1'b0;
      r_s1_data   <= '0;
      r_s1_addr   <= '0;
      r_flush     <= 1'b0;
      r_idx       <= '0;
      r_chain     <= 1'b0;
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
      r_byte      <= '0;
      for (int i = 0; i < PAR_WORDS; i++) r_bank[i] <= '0;
    end else if (fs_en) begin
      if (in_vld & (r_state != S_ACCUM)) r_err <= 1'b1;
      if (w_beat & ~(w_sel_ok & w_addr_ok)) r_err <= 1'b1;
      r_s1_vld  <= w_beat & w_sel_ok & w_addr_ok;
      r_s1_data <= w_rot;
      r_s1_addr <= par_addr;
      if (r_s1_vld)
        r_bank[r_s1_addr] <= r_bank[r_s1_addr] ^ r_s1_data;
      unique case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state <= S_ACCUM;
            r_mode  <= mode;
            r_chain <= 1'b0;
            for (int i = 0; i < PAR_WORDS; i++) r_bank[i] <= '0;
          end
        end
        S_ACCUM: begin
          if (frame_end) begin
            r_state <= S_FLUSH;
            r_flush <= 1'b0;
          end
        end
        S_FLUSH: begin
          r_flush <= 1'b1;
          if (r_flush) begin
            r_state     <= S_DRAIN;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (w_load) begin
            r_byte      <= (r_mode == MODE_CHAIN) ? w_cw : w_word;
            r_last      <= r_idx == PW_LAST;
            r_idx       <= r_idx + ADDR_W'(1);
            r_out_valid <= 1'b1;
            if (r_mode == MODE_CHAIN) r_chain <= w_c;
          end else if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
            if (r_last) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_state == S_ACCUM;
  assign out_valid = r_out_valid;
  assign out_last  = r_last;
  assign byte_out  = r_byte;
  assign err       = r_err;

endmodule

// File: tb/tb_ldpc_parity_accum_nut.sv
// Directed bench for the LDPC parity accumulate stage with
// hand-computed drain images.
module tb_ldpc_parity_accum_nut;

  logic         sys_clk = 1'b0;
  logic         rst = 1'b1;
  logic         fs_en = 1'b1;
  logic         mode = 1'b0;
  logic         frame_start = 1'b0;
  logic         in_vld = 1'b0;
  logic [359:0] ram_data = '0;
  logic [5:0]   slice_sel = '0;
  logic [2:0]   bit_rot = '0;
  logic [5:0]   par_addr = '0;
  logic         frame_end = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [7:0]   byte_out;
  logic         out_last;
  logic         err;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_w [45];

  ldpc_parity_accum_nut dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .fs_en       (fs_en),
    .mode        (mode),
    .frame_start (frame_start),
    .in_vld      (in_vld),
    .ram_data    (ram_data),
    .slice_sel   (slice_sel),
    .bit_rot     (bit_rot),
    .par_addr    (par_addr),
    .frame_end   (frame_end),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .byte_out    (byte_out),
    .out_last    (out_last),
    .err         (err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", tag, got, want);
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic start_frame(input logic m);
    mode        = m;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic beat(input int sel, input logic [7:0] val,
                      input int rot, input int addr,
                      input bit last);
    ram_data = '0;
    if (sel < 45) ram_data[sel*8 +: 8] = val;
    else ram_data = '1;
    slice_sel = 6'(sel);
    bit_rot   = 3'(rot);
    par_addr  = 6'(addr);
    in_vld    = 1'b1;
    frame_end = last;
    cyc();
    in_vld    = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    cyc();
    frame_end = 1'b0;
  endtask

  task automatic clear_exp(input logic [7:0] v);
    for (int i = 0; i < 45; i++) exp_w[i] = v;
  endtask

  task automatic drain(input bit stall);
    int got = 0;
    int n = 0;
    bit held_v = 0;
    logic [7:0] held = '0;
    while (got < 45 && n < 1000) begin
      out_ready = stall ? (n % 2 == 0) : 1'b1;
      fs_en     = stall ? ((n % 7) < 5) : 1'b1;
      if (held_v) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(byte_out), 32'(held));
      end
      if (out_valid && out_ready && fs_en) begin
        chk($sformatf("word%0d", got),
            32'(byte_out), 32'(exp_w[got]));
        chk($sformatf("last%0d", got),
            32'(out_last), 32'(got == 44));
        got++;
        held_v = 0;
      end else begin
        held_v = out_valid;
        held   = byte_out;
      end
      cyc();
      n++;
    end
    out_ready = 1'b1;
    fs_en     = 1'b1;
    chk("drain_count", 32'(got), 32'd45);
    chk("drain_done_valid", 32'(out_valid), 32'd0);
    chk("drain_done_idle", 32'(in_ready), 32'd0);
  endtask

  initial begin
    int n;
    #1;
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_byte_out", 32'(byte_out), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // single beat, mode 0
    start_frame(1'b0);
    chk("accum_ready", 32'(in_ready), 32'd1);
    beat(3, 8'hA5, 0, 0, 0);
    end_frame();
    clear_exp(8'h00);
    exp_w[0] = 8'hA5;
    drain(0);

    // forwarding, rotation, top slice, beat+end together
    start_frame(1'b0);
    beat(3, 8'hA5, 0, 7, 0);
    beat(3, 8'hA5, 0, 7, 0);
    beat(3, 8'h81, 0, 9, 0);
    beat(3, 8'h01, 0, 9, 0);
    beat(3, 8'h81, 1, 10, 0);
    beat(5, 8'h81, 4, 11, 0);
    beat(44, 8'h5A, 0, 44, 1);
    clear_exp(8'h00);
    exp_w[9]  = 8'h80;
    exp_w[10] = 8'h03;
    exp_w[11] = 8'h18;
    exp_w[44] = 8'h5A;
    drain(1);
    chk("no_err_legal", 32'(err), 32'd0);

    // running-XOR chain
    start_frame(1'b1);
    beat(0, 8'h80, 0, 0, 1);
    clear_exp(8'hFF);
    drain(1);

    // illegal slice_sel, then legal beat; bank untouched
    start_frame(1'b0);
    beat(45, 8'h00, 0, 2, 0);
    chk("err_sel", 32'(err), 32'd1);
    beat(3, 8'h22, 0, 2, 1);
    clear_exp(8'h00);
    exp_w[2] = 8'h22;
    drain(0);

    // illegal par_addr
    do_reset();
    start_frame(1'b0);
    beat(3, 8'h11, 0, 45, 1);
    chk("err_addr", 32'(err), 32'd1);
    clear_exp(8'h00);
    drain(0);
    chk("err_sticky", 32'(err), 32'd1);

    // in_vld while idle
    do_reset();
    in_vld = 1'b1;
    cyc();
    in_vld = 1'b0;
    chk("err_idle_vld", 32'(err), 32'd1);

    // reset in the middle of a drain
    do_reset();
    start_frame(1'b0);
    beat(3, 8'hA5, 0, 0, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("mid_valid_seen", 32'(out_valid), 32'd1);
    cyc();
    do_reset();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_byte", 32'(byte_out), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    start_frame(1'b0);
    chk("mid_rst_restart", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
